risc_core_param: RTL and testbench
==================================

Name: risc_core_param

Overview:
Parametrised successor to the fixed 8-bit, 4-register control_unit. It adds configurable data width and register count, an immediate operand mode, Z/C flags, and a valid/ready instruction handshake with a done pulse. The block is the execution core between the instruction source (switches or a fetch unit) and the display/debug logic. It keeps the FETCH/DECODE/EXECUTE/WRITEBACK sequencing.

Parameters:
DATA_W, 8, register and ALU width in bits (>=2)
NREGS, 4, number of general registers (power of 2, >=2); RSEL_W = clog2(NREGS)
INSTR_W, 4+2*RSEL_W (derived, localparam), instruction width

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
instr  input  INSTR_W  instruction {mode, op[2:0], rd[RSEL_W-1:0], rs[RSEL_W-1:0]}
instr_valid  input  1  instr holds a valid instruction
instr_ready  output  1  core can accept an instruction (high only in FETCH)
done  output  1  one-cycle pulse in WRITEBACK
dbg_sel  input  RSEL_W  register index for debug read
dbg_data  output  DATA_W  combinational read of register dbg_sel
flag_z  output  1  zero flag
flag_c  output  1  carry/borrow flag
state  output  2  FSM state: 0=FETCH, 1=DECODE, 2=EXECUTE, 3=WRITEBACK

Behaviour:
- Reset is synchronous, active-high, and takes priority over everything, including mid-instruction. On reset: state=FETCH, all registers=0, flag_z=0, flag_c=0, done=0, and any in-flight instruction is discarded without a write.
- FETCH: instr_ready=1. On an edge with instr_valid=1, latch instr into an internal IR and go to DECODE. Otherwise stay in FETCH.
- DECODE: read operands A=R[rd] and B. B is R[rs] when mode=0, or rs zero-extended to DATA_W when mode=1. Go to EXECUTE.
- EXECUTE: compute the result and next flags into internal registers. Go to WRITEBACK.
- WRITEBACK: done=1 for exactly this cycle. R[rd], flag_z and flag_c update on the edge leaving WRITEBACK. Go to FETCH.
- Latency: instruction accepted at edge N. done is high in the cycle after edge N+2. The new register value is visible on dbg_data after edge N+3.
- Throughput: 4 cycles per instruction when instr_valid is held high continuously.
- instr may change freely after acceptance; only IR is used.
- Opcodes (results modulo 2^DATA_W; C is carry-out for add and borrow for subtract):
  - 000 MOV: R[rd] = B; C unchanged.
  - 001 ADD: R[rd] = A + B; C = carry.
  - 010 SUB: R[rd] = A - B; C = borrow (A < B).
  - 011 INC: R[rd] = A + 1; C = carry; B ignored.
  - 100 DEC: R[rd] = A - 1; C = borrow (A == 0); B ignored.
  - 101 AND, 110 OR, 111 XOR: bitwise A op B; C = 0.
- flag_z = (result == 0) for every opcode, including MOV.
- rd == rs (for example ADD R0,R0) uses the pre-write values of both operands.
- dbg_data is combinational from the register file and reflects the write only after the commit edge.
- No state other than FETCH samples instr or instr_valid. instr_valid asserted outside FETCH is ignored, not queued.

Test Plan:
- DATA_W=8, NREGS=4. Reset high 2 cycles, then instr=0x30 (INC R0) with valid held; second 0x30; then 0x10 (ADD R0,R0). Required: done pulses 4 cycles apart; R0 goes 1, 2, 4; flag_z=0, flag_c=0.
- Handshake: valid low for 10 cycles after reset. Required: state stays 0, instr_ready=1, done=0. Raise valid with 0x87 (MOV R1,#3 immediate). Required: done exactly 3 cycles after the accept edge; R1=3 one cycle later.
- Wrap and flags: R2=0, DEC R2 (0x48). Required: R2=0xFF, C=1, Z=0. Then INC R2 (0x38). Required: R2=0x00, C=1, Z=1. Then XOR R2,R2. Required: Z=1, C=0.
- Reset mid-op: accept 0x30, assert reset in the EXECUTE cycle. Required: no write, R0=0, state=0, done never pulses; the next instruction behaves normally.
- Instruction change after accept: accept 0x30, then drive 0x48 during DECODE. Required: the INC result is written, not DEC.
- Parameter sweep DATA_W=16, NREGS=8 (INSTR_W=10). MOV R7,#7 then ADD R7,R7 repeated to 0xE000 then ADD. Required: 0xC000 with C=1; all eight registers independently readable via dbg_sel.

Source files
------------

// File: rtl/risc_core_param.sv
// Parametrised 4-phase execution core: FETCH/DECODE/EXECUTE/WRITEBACK over a DATA_W x NREGS register file.
// Latency: accept at edge N, done high after edge N+2, register/flags committed on edge N+3.
// Backpressure: instr_ready is high only in FETCH; instr_valid outside FETCH is ignored, never queued.
module risc_core_param #(
  parameter int DATA_W = 8,
  parameter int NREGS = 4,
  localparam int RSEL_W = $clog2(NREGS),
  localparam int INSTR_W = 4 + 2 * RSEL_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic               done,
  input  logic [RSEL_W-1:0]  dbg_sel,
  output logic [DATA_W-1:0]  dbg_data,
  output logic               flag_z,
  output logic               flag_c,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    S_FETCH     = 2'd0,
    S_DECODE    = 2'd1,
    S_EXECUTE   = 2'd2,
    S_WRITEBACK = 2'd3
  } state_t;

  state_t              st;
  logic [INSTR_W-1:0]  ir;
  logic [DATA_W-1:0]   regs [NREGS];
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [DATA_W-1:0]   res_q;
  logic                z_q;
  logic                c_q;

  // Instruction fields, always taken from the latched IR so instr may change after acceptance
  logic                ir_mode;
  logic [2:0]          ir_op;
  logic [RSEL_W-1:0]   ir_rd;
  logic [RSEL_W-1:0]   ir_rs;

  assign ir_mode  = ir[INSTR_W-1];
  assign ir_op    = ir[INSTR_W-2 -: 3];
  assign ir_rd    = ir[2*RSEL_W-1 -: RSEL_W];
  assign ir_rs    = ir[RSEL_W-1:0];

  assign state    = st;
  assign dbg_data = regs[dbg_sel];

  logic [DATA_W-1:0]   alu_res;
  logic                alu_c;
  logic [DATA_W:0]     wide;

  // ALU: result and carry/borrow from the operands captured in DECODE; MOV keeps the committed carry
  always_comb begin
    wide    = '0;
    alu_res = '0;
    alu_c   = flag_c;
    case (ir_op)
      3'b001: begin
        wide    = {1'b0, a_q} + {1'b0, b_q};
        alu_res = wide[DATA_W-1:0];
        alu_c   = wide[DATA_W];
      end
      3'b010: begin
        wide    = {1'b0, a_q} - {1'b0, b_q};
        alu_res = wide[DATA_W-1:0];
        alu_c   = wide[DATA_W];
      end
      3'b011: begin
        wide    = {1'b0, a_q} + {{DATA_W{1'b0}}, 1'b1};
        alu_res = wide[DATA_W-1:0];
        alu_c   = wide[DATA_W];
      end
      3'b100: begin
        wide    = {1'b0, a_q} - {{DATA_W{1'b0}}, 1'b1};
        alu_res = wide[DATA_W-1:0];
        alu_c   = wide[DATA_W];
      end
      3'b101: begin
        alu_res = a_q & b_q;
        alu_c   = 1'b0;
      end
      3'b110: begin
        alu_res = a_q | b_q;
        alu_c   = 1'b0;
      end
      3'b111: begin
        alu_res = a_q ^ b_q;
        alu_c   = 1'b0;
      end
      default: begin
        alu_res = b_q;
      end
    endcase
  end

  // Sequencer, pipeline registers, register file and flags; reset discards any in-flight instruction
  always_ff @(posedge clock) begin
    if (reset) begin
      st          <= S_FETCH;
      instr_ready <= 1'b1;
      done        <= 1'b0;
      flag_z      <= 1'b0;
      flag_c      <= 1'b0;
      ir          <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (st)
        S_FETCH: begin
          if (instr_valid) begin
            ir          <= instr;
            instr_ready <= 1'b0;
            st          <= S_DECODE;
          end
        end
        S_DECODE: begin
          // Both operands read before any write, so rd == rs sees pre-write values
          a_q <= regs[ir_rd];
          b_q <= ir_mode ? DATA_W'(ir_rs) : regs[ir_rs];
          st  <= S_EXECUTE;
        end
        S_EXECUTE: begin
          res_q <= alu_res;
          z_q   <= (alu_res == '0);
          c_q   <= alu_c;
          done  <= 1'b1;
          st    <= S_WRITEBACK;
        end
        default: begin
          regs[ir_rd] <= res_q;
          flag_z      <= z_q;
          flag_c      <= c_q;
          done        <= 1'b0;
          instr_ready <= 1'b1;
          st          <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_risc_core_param.sv
// Bench for risc_core_param: an 8-bit/4-reg instance and a 16-bit/8-reg instance on a shared clock and reset.
// Expected results are queued at instruction acceptance and compared after the commit edge.
// Runs to completion on its own with a global time bound.
module tb_risc_core_param;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // 8-bit, 4-register instance
  logic [7:0]  a_instr = '0;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic        a_done;
  logic [1:0]  a_sel = '0;
  logic [7:0]  a_dbg;
  logic        a_z;
  logic        a_c;
  logic [1:0]  a_state;

  // 16-bit, 8-register instance
  logic [9:0]  b_instr = '0;
  logic        b_valid = 1'b0;
  logic        b_ready;
  logic        b_done;
  logic [2:0]  b_sel = '0;
  logic [15:0] b_dbg;
  logic        b_z;
  logic        b_c;
  logic [1:0]  b_state;

  risc_core_param #(.DATA_W(8), .NREGS(4)) dut_a (
    .clock(clock), .reset(reset), .instr(a_instr), .instr_valid(a_valid),
    .instr_ready(a_ready), .done(a_done), .dbg_sel(a_sel), .dbg_data(a_dbg),
    .flag_z(a_z), .flag_c(a_c), .state(a_state)
  );

  risc_core_param #(.DATA_W(16), .NREGS(8)) dut_b (
    .clock(clock), .reset(reset), .instr(b_instr), .instr_valid(b_valid),
    .instr_ready(b_ready), .done(b_done), .dbg_sel(b_sel), .dbg_data(b_dbg),
    .flag_z(b_z), .flag_c(b_c), .state(b_state)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          b;
    int          rd;
    logic [31:0] res;
    bit          z;
    bit          c;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mr [2][8];
  bit          mz [2];
  bit          mc [2];

  localparam int K_ST = 0, K_RDY = 1, K_DONE = 2, K_DBG = 3, K_Z = 4, K_C = 5;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] obs(input bit b, input int k);
    logic [31:0] v;
    v = '0;
    case (k)
      K_ST:    v = b ? 32'(b_state) : 32'(a_state);
      K_RDY:   v = b ? 32'(b_ready) : 32'(a_ready);
      K_DONE:  v = b ? 32'(b_done)  : 32'(a_done);
      K_DBG:   v = b ? 32'(b_dbg)   : 32'(a_dbg);
      K_Z:     v = b ? 32'(b_z)     : 32'(a_z);
      K_C:     v = b ? 32'(b_c)     : 32'(a_c);
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic drive(input bit b, input logic [9:0] ins, input logic v);
    if (b) begin
      b_instr = ins;
      b_valid = v;
    end else begin
      a_instr = ins[7:0];
      a_valid = v;
    end
  endtask

  task automatic set_sel(input bit b, input int r);
    if (b) b_sel = 3'(r);
    else   a_sel = 2'(r);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 8; j++) mr[i][j] = '0;
      mz[i] = 1'b0;
      mc[i] = 1'b0;
    end
    sbq.delete();
  endtask

  // Reference behaviour of one instruction; queues the expected commit and updates the model
  task automatic model(input bit b, input logic [9:0] ins);
    int          w, sw, op, rd, rs;
    bit          mode;
    logic [31:0] mask, a, bv, t, res;
    bit          c;
    exp_t        e;
    w    = b ? 16 : 8;
    sw   = b ? 3 : 2;
    mask = (32'd1 << w) - 32'd1;
    rs   = int'(ins) & ((1 << sw) - 1);
    rd   = (int'(ins) >> sw) & ((1 << sw) - 1);
    op   = (int'(ins) >> (2 * sw)) & 7;
    mode = ins[2*sw+3];
    a    = mr[b][rd];
    bv   = mode ? 32'(rs) : mr[b][rs];
    c    = mc[b];
    t    = '0;
    res  = '0;
    case (op)
      0: res = bv;
      1: begin t = a + bv; res = t & mask; c = t[w]; end
      2: begin res = (a - bv) & mask; c = (a < bv); end
      3: begin t = a + 32'd1; res = t & mask; c = t[w]; end
      4: begin res = (a - 32'd1) & mask; c = (a == 0); end
      5: begin res = a & bv; c = 1'b0; end
      6: begin res = a | bv; c = 1'b0; end
      default: begin res = a ^ bv; c = 1'b0; end
    endcase
    e.b = b; e.rd = rd; e.res = res; e.z = (res == 0); e.c = c;
    sbq.push_back(e);
    mr[b][rd] = res;
    mz[b] = e.z;
    mc[b] = c;
  endtask

  // Issue one instruction from a negedge; post is driven on instr right after acceptance
  task automatic exec(input bit b, input logic [9:0] ins, input logic [9:0] post);
    int   n;
    exp_t e;
    n = 0;
    while (obs(b, K_RDY) != 32'd1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("ready_before_issue", obs(b, K_RDY), 32'd1);
    drive(b, ins, 1'b1);
    @(posedge clock);
    model(b, ins);
    @(negedge clock);
    drive(b, post, 1'b1);
    chk("decode_state", obs(b, K_ST), 32'd1);
    chk("decode_done", obs(b, K_DONE), 32'd0);
    chk("decode_ready", obs(b, K_RDY), 32'd0);
    @(negedge clock);
    chk("execute_state", obs(b, K_ST), 32'd2);
    chk("execute_done", obs(b, K_DONE), 32'd0);
    @(negedge clock);
    chk("writeback_state", obs(b, K_ST), 32'd3);
    chk("writeback_done", obs(b, K_DONE), 32'd1);
    @(negedge clock);
    drive(b, post, 1'b0);
    chk("fetch_state", obs(b, K_ST), 32'd0);
    chk("fetch_done", obs(b, K_DONE), 32'd0);
    if (sbq.size() == 0) begin
      chk("scoreboard_empty", 32'(sbq.size()), 32'd1);
    end else begin
      e = sbq.pop_front();
      set_sel(e.b, e.rd);
      #1;
      chk("reg_value", obs(b, K_DBG), e.res);
      chk("flag_z", obs(b, K_Z), 32'(e.z));
      chk("flag_c", obs(b, K_C), 32'(e.c));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, '0, 1'b0);
    drive(1, '0, 1'b0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time bound expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset();

    for (int b = 0; b < 2; b++) begin
      chk("rst_state", obs(b[0], K_ST), 32'd0);
      chk("rst_ready", obs(b[0], K_RDY), 32'd1);
      chk("rst_done", obs(b[0], K_DONE), 32'd0);
      chk("rst_z", obs(b[0], K_Z), 32'd0);
      chk("rst_c", obs(b[0], K_C), 32'd0);
    end
    for (int r = 0; r < 8; r++) begin
      b_sel = 3'(r);
      a_sel = 2'(r);
      #1;
      chk("rst_reg_b", 32'(b_dbg), 32'd0);
      if (r < 4) chk("rst_reg_a", 32'(a_dbg), 32'd0);
    end

    // Idle handshake: nothing offered for 10 cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("idle_state", 32'(a_state), 32'd0);
      chk("idle_ready", 32'(a_ready), 32'd1);
      chk("idle_done", 32'(a_done), 32'd0);
    end
    exec(0, 10'h087, 10'($urandom));
    chk("mov_imm_r1", 32'(a_dbg), 32'd3);

    // INC, INC, ADD R0,R0 back to back
    exec(0, 10'h030, 10'($urandom));
    chk("r0_first_inc", 32'(a_dbg), 32'd1);
    exec(0, 10'h030, 10'($urandom));
    chk("r0_second_inc", 32'(a_dbg), 32'd2);
    exec(0, 10'h010, 10'($urandom));
    chk("r0_add_self", 32'(a_dbg), 32'd4);
    chk("r0_add_z", 32'(a_z), 32'd0);
    chk("r0_add_c", 32'(a_c), 32'd0);

    // Wrap and flags on R2
    exec(0, 10'h048, 10'($urandom));
    chk("dec_wrap_val", 32'(a_dbg), 32'hFF);
    chk("dec_wrap_c", 32'(a_c), 32'd1);
    chk("dec_wrap_z", 32'(a_z), 32'd0);
    exec(0, 10'h038, 10'($urandom));
    chk("inc_wrap_val", 32'(a_dbg), 32'h00);
    chk("inc_wrap_c", 32'(a_c), 32'd1);
    chk("inc_wrap_z", 32'(a_z), 32'd1);
    exec(0, 10'h07A, 10'($urandom));
    chk("xor_self_z", 32'(a_z), 32'd1);
    chk("xor_self_c", 32'(a_c), 32'd0);

    // Reset arriving while an INC R0 is in EXECUTE
    do_reset();
    a_instr = 8'h30;
    a_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    a_valid = 1'b0;
    chk("midrst_decode", 32'(a_state), 32'd1);
    @(negedge clock);
    chk("midrst_execute", 32'(a_state), 32'd2);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    chk("midrst_state", 32'(a_state), 32'd0);
    for (int i = 0; i < 6; i++) begin
      a_sel = 2'd0;
      #1;
      chk("midrst_no_done", 32'(a_done), 32'd0);
      chk("midrst_r0", 32'(a_dbg), 32'd0);
      @(negedge clock);
    end
    exec(0, 10'h030, 10'($urandom));
    chk("after_rst_inc", 32'(a_dbg), 32'd1);

    // DEC presented on instr during DECODE must not replace the accepted INC
    exec(0, 10'h030, 10'h048);
    chk("ir_held_r0", 32'(a_dbg), 32'd2);
    a_sel = 2'd2;
    #1;
    chk("ir_held_r2", 32'(a_dbg), 32'd0);

    // Wide instance: distinct immediates into R0..R6, then doubling R7
    for (int i = 0; i < 7; i++) begin
      exec(1, {1'b1, 3'b000, 3'(i), 3'(i)}, 10'($urandom));
    end
    exec(1, 10'h23F, 10'($urandom));
    chk("b_mov_r7", 32'(b_dbg), 32'd7);
    for (int i = 0; i < 13; i++) begin
      exec(1, 10'h07F, 10'($urandom));
    end
    chk("b_r7_e000", 32'(b_dbg), 32'hE000);
    exec(1, 10'h07F, 10'($urandom));
    chk("b_r7_c000", 32'(b_dbg), 32'hC000);
    chk("b_r7_carry", 32'(b_c), 32'd1);
    chk("b_r7_z", 32'(b_z), 32'd0);
    for (int r = 0; r < 8; r++) begin
      b_sel = 3'(r);
      #1;
      chk("b_regfile", 32'(b_dbg), (r < 7) ? 32'(r) : 32'hC000);
    end
    chk("a_idle_during_b", 32'(a_state), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
